// File: rtl/dl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dl_pkg
// Description : Shared types and constants for the download/boot sequencer:
//               sequencer state encoding, ioctl index map, game identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package dl_pkg;

    // Sequencer states: explicit 2-bit encoding
    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } dl_state_t;

    // ioctl_index destination map
    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    // mod value meaning "no game selected yet"
    localparam logic [7:0] MOD_NONE = 8'hFF;

    // Game identifiers carried in the mod byte
    localparam logic [7:0] GAME_BATTLEZONE = 8'd0;
    localparam logic [7:0] GAME_BRADLEY    = 8'd1;
    localparam logic [7:0] GAME_REDBARON   = 8'd2;

    // Saturating increment: an oversized ROM must never wrap back to a
    // count that happens to match the expected size.
    function automatic logic [24:0] sat_inc(input logic [24:0] v);
        return (&v) ? v : v + 25'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dl_sequencer_rst_stretch.sv
`default_nettype none
// ============================================================================
// Module      : rst_stretch
// Description : Loadable down-counter that times the core-reset stretch.
//               load reloads RST_CYCLES-1, en decrements until zero,
//               done flags a zero count.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_stretch #(
    parameter int RST_CYCLES = 1024
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int              CW       = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CW-1:0]   C_RELOAD = CW'(RST_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Reload has priority; otherwise count down and park at zero
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= C_RELOAD;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/dl_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dl_sequencer
// Description : Routes hps_io ioctl bytes to ROM / mod / DIP destinations,
//               holds the core in reset during downloads and stretches the
//               reset afterwards. core_reset is a single registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module dl_sequencer
    import dl_pkg::*;
#(
    parameter int          RST_CYCLES = 1024,
    parameter logic [24:0] ROM_BYTES  = 25'h10000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    input  logic        user_rst,
    output logic        rom_wr,
    output logic [24:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [7:0]  mod,
    output logic [63:0] dsw,
    output logic        core_reset,
    output logic        rom_ok
);

    dl_state_t   r_state;
    logic [7:0]  r_cur_idx;
    logic [24:0] r_byte_cnt;

    logic        w_enter_load;
    logic        w_wr_ok;
    logic        w_rom_hit;
    logic        w_mod_hit;
    logic        w_dip_hit;
    logic        w_dl_end;
    logic        w_stretch_load;
    logic        w_stretch_en;
    logic        w_stretch_done;
    logic [24:0] w_cnt_next;

    // A rising download pre-empts every other state; LOAD itself stays put
    assign w_enter_load = ioctl_download && (r_state != LOAD);

    // Byte decode uses the live index; writes count only while in LOAD
    assign w_wr_ok   = (r_state == LOAD) && ioctl_wr;
    assign w_rom_hit = w_wr_ok && (ioctl_index == IDX_ROM);
    assign w_mod_hit = w_wr_ok && (ioctl_index == IDX_MOD);
    assign w_dip_hit = w_wr_ok && (ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == 22'd0);

    // Count including the byte of this cycle, so a write coincident with
    // the falling download edge is part of the size check.
    assign w_cnt_next = w_rom_hit ? sat_inc(r_byte_cnt) : r_byte_cnt;

    assign w_dl_end = (r_state == LOAD) && !ioctl_download;

    // Stretch starts at download end, or on user reset from RUN/SETTLE
    // (a simultaneous download wins, so user_rst is masked by it).
    assign w_stretch_load = w_dl_end ||
                            (!ioctl_download && user_rst &&
                             ((r_state == RUN) || (r_state == SETTLE)));
    assign w_stretch_en   = (r_state == SETTLE);

    rst_stretch #(
        .RST_CYCLES (RST_CYCLES)
    ) u_rst_stretch (
        .clk_sys (clk_sys),
        .reset   (reset),
        .load    (w_stretch_load),
        .en      (w_stretch_en),
        .done    (w_stretch_done)
    );

    // Sequencer state machine with registered byte routing and core reset
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state    <= HOLD;
            r_cur_idx  <= IDX_ROM;
            r_byte_cnt <= '0;
            rom_wr     <= 1'b0;
            rom_addr   <= '0;
            rom_data   <= '0;
            mod        <= MOD_NONE;
            dsw        <= '0;
            core_reset <= 1'b1;
            rom_ok     <= 1'b0;
        end else begin
            rom_wr     <= w_rom_hit;
            r_byte_cnt <= w_cnt_next;
            core_reset <= (r_state != RUN);

            if (w_rom_hit) begin
                rom_addr <= ioctl_addr;
                rom_data <= ioctl_dout;
            end
            if (w_mod_hit) begin
                mod <= ioctl_dout;
            end
            if (w_dip_hit) begin
                dsw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
            end

            if (w_enter_load) begin
                r_state   <= LOAD;
                r_cur_idx <= ioctl_index;
                if (ioctl_index == IDX_ROM) begin
                    r_byte_cnt <= '0;
                end
            end else begin
                case (r_state)
                    LOAD: begin
                        if (!ioctl_download) begin
                            // Only a ROM download re-judges ROM validity
                            if (r_cur_idx == IDX_ROM) begin
                                rom_ok <= (w_cnt_next == ROM_BYTES);
                            end
                            r_state <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        // A held user_rst keeps reloading the stretch
                        if (!user_rst && w_stretch_done) begin
                            r_state <= rom_ok ? RUN : HOLD;
                        end
                    end
                    RUN: begin
                        if (user_rst) begin
                            r_state <= SETTLE;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dl_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dl_sequencer
// Description : Scoreboard bench for dl_sequencer. Stimulus pushes expected
//               ROM writes and core_reset edges into queues; monitors pop
//               and compare when the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dl_sequencer;

    localparam int          R  = 16;
    localparam int          RB = 64;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        user_rst = 1'b0;
    logic        rom_wr;
    logic [24:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  mod;
    logic [63:0] dsw;
    logic        core_reset;
    logic        rom_ok;

    dl_sequencer #(
        .RST_CYCLES (R),
        .ROM_BYTES  (25'(RB))
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .user_rst       (user_rst),
        .rom_wr         (rom_wr),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .mod            (mod),
        .dsw            (dsw),
        .core_reset     (core_reset),
        .rom_ok         (rom_ok)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    typedef struct { logic [24:0] addr; logic [7:0] data; int cyc; } rom_exp_t;
    typedef struct { logic val; int cyc; } cr_exp_t;
    rom_exp_t rom_q[$];
    cr_exp_t  cr_q[$];

    // Reference model state
    bit          m_run = 1'b0;
    bit          m_rom_ok = 1'b0;
    logic [7:0]  m_mod = 8'hFF;
    logic [63:0] m_dsw = '0;
    int          m_cnt = 0;
    logic [7:0]  m_idx = 8'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ROM write monitor
    initial begin
        rom_exp_t e;
        forever begin
            @(negedge clk_sys);
            if (!reset && rom_wr !== 1'b0) begin
                if (rom_q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL rom_wr_spurious: got rom_wr=%b addr %0h expected no write (cycle %0d)", rom_wr, rom_addr, cyc);
                end else begin
                    e = rom_q.pop_front();
                    chk("rom_addr", 64'(rom_addr), 64'(e.addr));
                    chk("rom_data", 64'(rom_data), 64'(e.data));
                    chk("rom_wr_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // core_reset edge monitor
    initial begin
        cr_exp_t e;
        logic    prev;
        prev = 1'b1;
        forever begin
            @(negedge clk_sys);
            if (reset) begin
                prev = 1'b1;
            end else if (core_reset !== prev) begin
                if (cr_q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL core_reset_spurious: got %b expected %b (cycle %0d)", core_reset, prev, cyc);
                end else begin
                    e = cr_q.pop_front();
                    chk("core_reset_edge_val", 64'(core_reset), 64'(e.val));
                    chk("core_reset_edge_cycle", 64'(cyc), 64'(e.cyc));
                end
                prev = core_reset;
            end
        end
    end

    task automatic check_state(input string tag);
        chk({tag, "_core_reset"}, 64'(core_reset), 64'(!m_run));
        chk({tag, "_rom_ok"}, 64'(rom_ok), 64'(m_rom_ok));
        chk({tag, "_mod"}, 64'(mod), 64'(m_mod));
        chk({tag, "_dsw"}, dsw, m_dsw);
    endtask

    // Begin a download; a running core is expected to drop into reset 2 cycles on
    task automatic dl_start(input logic [7:0] idx, input bit with_urst);
        if (m_run) cr_q.push_back('{1'b1, cyc + 2});
        ioctl_download = 1'b1;
        ioctl_index    = idx;
        user_rst       = with_urst;
        m_idx = idx;
        if (idx == 8'd0) m_cnt = 0;
        m_run = 1'b0;
        @(negedge clk_sys);
        user_rst = 1'b0;
    endtask

    // Download ended at drive cycle n: valid ROM means core released R+2 later
    task automatic dl_finish(input int n);
        if (m_idx == 8'd0) m_rom_ok = (m_cnt == RB);
        if (m_rom_ok) begin
            cr_q.push_back('{1'b0, n + R + 2});
            m_run = 1'b1;
        end
        repeat (R + 6) @(negedge clk_sys);
    endtask

    task automatic dl_byte(input logic [24:0] addr, input logic [7:0] data, input bit last);
        int n;
        repeat ($urandom_range(0, 2)) @(negedge clk_sys);
        ioctl_wr   = 1'b1;
        ioctl_addr = addr;
        ioctl_dout = data;
        if (last) ioctl_download = 1'b0;
        n = cyc;
        if (m_idx == 8'd0) begin
            rom_q.push_back('{addr, data, n + 1});
            m_cnt++;
        end else if (m_idx == 8'd1) begin
            m_mod = data;
        end else if (m_idx == 8'd254 && addr < 25'd8) begin
            m_dsw[addr[2:0]*8 +: 8] = data;
        end
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        if (last) dl_finish(n);
    endtask

    task automatic dl_stop();
        int n;
        ioctl_download = 1'b0;
        n = cyc;
        @(negedge clk_sys);
        dl_finish(n);
    endtask

    task automatic rom_dl(input int nb, input bit last_on_fall);
        dl_start(8'd0, 1'b0);
        for (int i = 0; i < nb; i++)
            dl_byte(25'(i), 8'($urandom), last_on_fall && (i == nb - 1));
        if (!last_on_fall) dl_stop();
    endtask

    task automatic urst_pulse(input int len);
        user_rst = 1'b1;
        cr_q.push_back('{1'b1, cyc + 2});
        repeat (len) @(negedge clk_sys);
        user_rst = 1'b0;
        cr_q.push_back('{1'b0, cyc + 1 + R});
        repeat (R + 6) @(negedge clk_sys);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int sel;
        int nb;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (40) @(negedge clk_sys);
        check_state("idle");

        rom_dl(RB, 1'b1);
        check_state("rom_full");
        rom_dl(RB - 1, 1'b0);
        check_state("rom_short");
        rom_dl(RB, 1'b0);
        check_state("rom_reload");

        dl_start(8'd254, 1'b0);
        dl_byte(25'd0, 8'hAA, 1'b0);
        dl_byte(25'd1, 8'h55, 1'b0);
        dl_byte(25'd8, 8'h77, 1'b1);
        check_state("dip");
        chk("dsw_low16", 64'(dsw[15:0]), 64'h55AA);
        chk("dsw_high48", 64'(dsw[63:16]), 64'h0);

        dl_start(8'd1, 1'b0);
        dl_byte(25'd0, 8'h02, 1'b1);
        chk("mod_02", 64'(mod), 64'h02);
        urst_pulse(10);
        check_state("urst");

        // Other index with a simultaneous user_rst: download wins, bytes dropped
        dl_start(8'd9, 1'b1);
        for (int i = 0; i < 5; i++)
            dl_byte(25'($urandom_range(0, 15)), 8'($urandom), i == 4);
        check_state("other_idx");

        for (int r = 0; r < 10; r++) begin
            if (m_run && $urandom_range(0, 1) == 1) urst_pulse($urandom_range(1, 5));
            sel = $urandom_range(0, 3);
            case (sel)
                0: begin
                    nb = RB - 1 + $urandom_range(0, 2);
                    rom_dl(nb, 1'($urandom_range(0, 1)));
                end
                1: begin
                    dl_start(8'd1, 1'b0);
                    nb = $urandom_range(1, 3);
                    for (int i = 0; i < nb; i++) dl_byte(25'(i), 8'($urandom), i == nb - 1);
                end
                2: begin
                    dl_start(8'd254, 1'b0);
                    nb = $urandom_range(1, 4);
                    for (int i = 0; i < nb; i++)
                        dl_byte(25'($urandom_range(0, 15)), 8'($urandom), i == nb - 1);
                end
                default: begin
                    dl_start(8'($urandom_range(2, 253)), 1'b0);
                    dl_byte(25'($urandom_range(0, 15)), 8'($urandom), 1'b0);
                    dl_stop();
                end
            endcase
            check_state("random");
        end

        // Reset partway through a ROM download
        rom_dl(RB, 1'b0);
        dl_start(8'd0, 1'b0);
        for (int i = 0; i < 30; i++) dl_byte(25'(i), 8'($urandom), 1'b0);
        @(negedge clk_sys);
        #1;
        reset = 1'b1;
        ioctl_download = 1'b0;
        m_run = 1'b0; m_rom_ok = 1'b0; m_mod = 8'hFF; m_dsw = '0;
        #1;
        chk("async_core_reset", 64'(core_reset), 64'h1);
        chk("async_rom_wr", 64'(rom_wr), 64'h0);
        chk("async_mod", 64'(mod), 64'hFF);
        chk("async_dsw", dsw, 64'h0);
        chk("async_rom_ok", 64'(rom_ok), 64'h0);
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (10) @(negedge clk_sys);
        check_state("post_reset");
        rom_dl(RB, 1'b1);
        check_state("recover");

        chk("rom_queue_drained", 64'(rom_q.size()), 64'h0);
        chk("core_reset_queue_drained", 64'(cr_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dl_sequencer.md
# dl_sequencer

Download and boot sequencer between `hps_io` and the game core. It routes HPS ioctl bytes by `ioctl_index` to three destinations: the ROM download port, the game-select (`mod`) register and the DIP-switch bank. It holds the core in reset while a download is in progress and stretches that reset after the download ends. It gives the core one registered, glitch-free `core_reset` that merges every reset source.

## Interface
- `RST_CYCLES`, default 1024: length in clk_sys cycles of the post-download / user-reset stretch. Minimum 2.
- `ROM_BYTES`, default 25'h10000: expected byte count of an index-0 download.
- `clk_sys` in 1: system clock, the `hps_io` clock domain.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `ioctl_download` in 1: download active.
- `ioctl_wr` in 1: byte strobe, one cycle per byte.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `ioctl_index` in 8: destination select (0 = ROM, 1 = mod, 254 = DIP).
- `user_rst` in 1: level request (OSD reset OR button). Synchronous to clk_sys.
- `rom_wr` out 1: ROM write strobe.
- `rom_addr` out 25: ROM write address.
- `rom_data` out 8: ROM write data.
- `mod` out 8: game-select byte. Reset value 8'hFF.
- `dsw` out 64: DIP bytes 0..7, with byte n at bits [8n+7:8n]. Reset value 0.
- `core_reset` out 1: active-high reset to the core. Reset value 1.
- `rom_ok` out 1: the last index-0 download delivered exactly `ROM_BYTES` bytes. Reset value 0.

## Operation
- State machine states: HOLD, LOAD, SETTLE, RUN. The reset state is HOLD.
- HOLD: `core_reset` = 1. Wait for a download.
  - If `ioctl_download` = 1, go to LOAD.
  - HOLD is never left without passing through LOAD. The core does not run until something has been downloaded.
- LOAD: `core_reset` = 1.
  - On entry: latch `ioctl_index` into `cur_idx`. If `cur_idx` = 0, clear the byte counter.
  - Each `ioctl_wr` is decoded using the live `ioctl_index`:
    - index 0: forward the byte to the `rom_*` outputs and increment the byte counter.
    - index 1: `mod` <= `ioctl_dout`.
    - index 254 with `ioctl_addr[24:3]` = 0: write DIP byte `ioctl_addr[2:0]`.
    - Any other index, or an index-254 address at or above 8: the byte is discarded with no side effect.
  - When `ioctl_download` falls: if `cur_idx` = 0, `rom_ok` <= (count == `ROM_BYTES`). Then load the stretch counter with `RST_CYCLES`-1 and go to SETTLE.
- SETTLE: `core_reset` = 1. The counter decrements once per cycle.
  - If the counter = 0 and `rom_ok` = 1, go to RUN.
  - If the counter = 0 and `rom_ok` = 0, go to HOLD.
  - If `ioctl_download` rises, go to LOAD immediately.
  - If `user_rst` is held, reload the counter every cycle.
- RUN: `core_reset` = 0.
  - If `ioctl_download` = 1, go to LOAD.
  - Else if `user_rst` = 1, reload the counter and go to SETTLE.
  - If both are asserted in the same cycle, the download wins.
- DIP-only or mod-only downloads (`cur_idx` ≠ 0) leave `rom_ok` unchanged. With a valid ROM already loaded, such a download returns to RUN after the stretch.
- The byte counter is 25 bits and saturates at all-ones; it never wraps. Overflow therefore yields `rom_ok` = 0.
- Asynchronous `reset` mid-download: all outputs return to their reset values, including `mod` = FF, `dsw` = 0 and `rom_ok` = 0. The state goes to HOLD. A partial ROM is not marked valid.

## Timing
- `rom_wr`, `rom_addr` and `rom_data` are registered: latency is 1 cycle from `ioctl_wr`.
  - `rom_wr` is a single-cycle pulse per accepted byte.
  - `rom_addr` and `rom_data` hold their values between pulses.
- `mod` and `dsw` update 1 cycle after `ioctl_wr`.
- `core_reset` is registered directly from the state.
  - It rises 1 cycle after `ioctl_download` or `user_rst` is sampled in RUN.
  - After `ioctl_download` falls, it stays high for exactly `RST_CYCLES`+1 cycles, provided `user_rst` is low throughout.
- After `user_rst` deasserts in SETTLE, `core_reset` stays high for exactly `RST_CYCLES` more cycles.
- A `ioctl_wr` that arrives in the same cycle that `ioctl_download` falls is still accepted and counted.
- Any `ioctl_wr` outside LOAD is ignored.

## Structure
- Shared package `dl_pkg`:
  - state enum `dl_state_t`;
  - index constants `IDX_ROM` = 0, `IDX_MOD` = 1, `IDX_DIP` = 254;
  - `MOD_NONE` = 8'hFF;
  - game-id constants (battlezone 0, bradley 1, redbaron 2).
- One sub-module, `rst_stretch`: the loadable down-counter with a reload input and a `done` output, parameterised by `RST_CYCLES`.
- Everything else is flat in `dl_sequencer`.

## Test plan
- Release `reset`, no download: `core_reset` = 1 indefinitely, `mod` = FF, `dsw` = 0, `rom_ok` = 0.
- Index-0 download of 65536 bytes (`ROM_BYTES` default) at addresses 0..FFFF: 65536 `rom_wr` pulses, each 1 cycle after its `ioctl_wr` with matching addr/data. `rom_ok` = 1. `core_reset` falls exactly 1025 cycles after `ioctl_download` falls.
- Index-0 download of 65535 bytes: `rom_ok` = 0. Back to HOLD; `core_reset` stays 1.
- Index-254 writes of AA to address 0, 55 to address 1, and 77 to address 8: `dsw[15:0]` = 16'h55AA, `dsw[63:16]` = 0. With a valid ROM already loaded, RUN resumes after 1025 cycles.
- Index-1 write of 02, then `user_rst` pulsed for 10 cycles in RUN: `mod` = 02. `core_reset` rises the next cycle and falls 1024 cycles after `user_rst` deasserts.
- Assert `reset` at byte 300 of an index-0 download: all outputs return to their reset values asynchronously, with no further `rom_wr`. A subsequent full download recovers to RUN.
